// File: rtl/pong_pkg.sv
// Shared pong constants and the paddle FSM state type.
package pong_pkg;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int PADDLE_HEIGHT = 100;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN
    } paddle_state_t;

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle control bus: raw buttons and frame strobe in, paddle position and flags out.
interface paddle_ctrl_if;

    logic       btn_up;
    logic       btn_down;
    logic       frame;
    logic [9:0] pad_top_pixel;
    logic       moving;
    logic       at_top;
    logic       at_bottom;

    modport master (
        output btn_up, btn_down, frame,
        input  pad_top_pixel, moving, at_top, at_bottom
    );

    modport slave (
        input  btn_up, btn_down, frame,
        output pad_top_pixel, moving, at_top, at_bottom
    );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stability counter; level flips only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock_25M,
    input  logic reset_n,
    input  logic btn,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock_25M or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Per-player paddle controller: debounced buttons drive a per-frame paddle move
// with a speed ramp, clamped to the visible screen.
module paddle_ctrl #(
    parameter int SCREEN_HEIGHT   = pong_pkg::SCREEN_HEIGHT,
    parameter int PADDLE_HEIGHT   = pong_pkg::PADDLE_HEIGHT,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SPEED_MIN       = 2,
    parameter int SPEED_MAX       = 8,
    parameter int ACCEL_FRAMES    = 4
) (
    input  logic           clock_25M,
    input  logic           reset_n,
    paddle_ctrl_if.slave   pad
);

    import pong_pkg::*;

    localparam int MAX_POS   = SCREEN_HEIGHT - PADDLE_HEIGHT;
    localparam int START_POS = MAX_POS / 2;
    localparam int SW        = $clog2(SPEED_MAX + 1);
    localparam int AW        = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic signed [10:0] MAX_S = signed'(11'(MAX_POS));

    logic          up_db;
    logic          down_db;
    paddle_state_t state;
    paddle_state_t req;
    logic [SW-1:0] speed;
    logic [SW-1:0] step;
    logic [AW-1:0] cnt;
    logic [9:0]    pos;
    logic [9:0]    npos;
    logic signed [10:0] cand;
    logic          moving_r;
    logic          at_top_r;
    logic          at_bottom_r;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clock_25M (clock_25M),
        .reset_n   (reset_n),
        .btn       (pad.btn_up),
        .level     (up_db)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clock_25M (clock_25M),
        .reset_n   (reset_n),
        .btn       (pad.btn_down),
        .level     (down_db)
    );

    always_comb begin
        req = IDLE;
        if (up_db && !down_db) begin
            req = MOVE_UP;
        end else if (down_db && !up_db) begin
            req = MOVE_DOWN;
        end
    end

    // Signed 11-bit candidate so an upward step below row 0 clamps instead of wrapping.
    always_comb begin
        step = (req == state) ? speed : SW'(SPEED_MIN);
        if (req == MOVE_UP) begin
            cand = signed'({1'b0, pos}) - signed'(11'(step));
        end else begin
            cand = signed'({1'b0, pos}) + signed'(11'(step));
        end
        if (cand < 0) begin
            npos = '0;
        end else if (cand > MAX_S) begin
            npos = 10'(MAX_POS);
        end else begin
            npos = cand[9:0];
        end
    end

    always_ff @(posedge clock_25M or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            speed       <= SW'(SPEED_MIN);
            cnt         <= '0;
            pos         <= 10'(START_POS);
            moving_r    <= 1'b0;
            at_top_r    <= 1'b0;
            at_bottom_r <= 1'b0;
        end else if (pad.frame) begin
            if (req == IDLE) begin
                state    <= IDLE;
                speed    <= SW'(SPEED_MIN);
                cnt      <= '0;
                moving_r <= 1'b0;
            end else begin
                state       <= req;
                pos         <= npos;
                moving_r    <= (npos != pos);
                at_top_r    <= (npos == '0);
                at_bottom_r <= (npos == 10'(MAX_POS));
                if (req != state) begin
                    speed <= SW'(SPEED_MIN);
                    cnt   <= (ACCEL_FRAMES == 1) ? AW'(0) : AW'(1);
                end else if (cnt == AW'(ACCEL_FRAMES - 1)) begin
                    cnt <= '0;
                    if (speed < SW'(SPEED_MAX)) begin
                        speed <= speed + SW'(1);
                    end
                end else begin
                    cnt <= cnt + AW'(1);
                end
            end
        end
    end

    assign pad.pad_top_pixel = pos;
    assign pad.moving        = moving_r;
    assign pad.at_top        = at_top_r;
    assign pad.at_bottom     = at_bottom_r;

endmodule
